// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS32 control sequencer: decodes the IR opcode and steps the shared-memory datapath
// through fetch/decode/execute, stalling on mem_ready and trapping on unsupported opcodes.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        RWB    = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        ADDIEX = 4'd11,
        ADDIWB = 4'd12,
        TRAP   = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    state_t state_q;
    state_t next_state;
    ctrl_t  ctrl_q;
    logic   retire;
    logic   fetch_strobe;

    // Moore part of the control word for a given state; the registered copy is loaded from the
    // next state so the outputs line up with the state they belong to.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE: c.alu_src_b = 2'b11;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            RWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDIWB: c.reg_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Retiring states share one exit: go straight to the next fetch or park in IDLE depending on run.
    always_comb begin
        next_state = state_q;
        retire     = 1'b0;
        case (state_q)
            IDLE:   if (run) next_state = FETCH;
            FETCH:  if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = EXEC;
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDIEX;
                    default:      next_state = TRAP;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW)      next_state = MEMRD;
                else if (opcode == OP_SW) next_state = MEMWR;
                else                      next_state = TRAP;
            end
            MEMRD:  if (mem_ready) next_state = MEMWB;
            MEMWR:  if (mem_ready) retire = 1'b1;
            EXEC:   next_state = RWB;
            ADDIEX: next_state = ADDIWB;
            MEMWB, RWB, BRANCH, JUMP, ADDIWB: retire = 1'b1;
            TRAP:   next_state = TRAP;
            default: next_state = IDLE;
        endcase
        if (retire) next_state = run ? FETCH : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            trap        <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= next_state;
            ctrl_q  <= decode_ctrl(next_state);
            if (next_state == TRAP) trap <= 1'b1;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    // IR and PC are only loaded on the cycle the fetch read actually completes.
    assign fetch_strobe = (state_q == FETCH) && mem_ready;

    assign PCWrite     = ctrl_q.pc_write | fetch_strobe;
    assign IRWrite     = fetch_strobe;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemToReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign state       = state_q;

endmodule
